serial_frame_deser: RTL and testbench
=====================================

// Module: serial_frame_deser
// PURPOSE
//  Downstream consumer of the single-bit registered input stage (sync-reset DFF, clk/reset/i -> y).
//  Hunts the registered serial bit stream for a sync word, then deserialises DATA_W payload bits
//  (MSB first) plus an optional even-parity bit into a parallel word.
//  Emits a one-cycle valid pulse per frame. Port i is wired to that stage's output y.
// PARAMETERS
//  DATA_W     8        payload width in bits (2..32)
//  SYNC_W     4        sync word width in bits (2..8)
//  SYNC       4'b1011  sync pattern, first-received bit is MSB
//  PARITY_EN  1        1: one even-parity bit follows payload; 0: no parity bit
// PORTS
//  clk         in   1       rising-edge clock, single clock domain
//  reset       in   1       synchronous, active-high reset
//  i           in   1       serial bit, one bit sampled per rising edge of clk
//  data_out    out  DATA_W  last completed payload, held until the next frame completes
//  valid       out  1       one-cycle pulse: data_out/parity_err updated this cycle
//  parity_err  out  1       1 = received parity mismatched; meaningful when valid=1, held after
//  busy        out  1       1 while in DATA or PARITY state
// BEHAVIOUR
//  - Reset (reset=1 at a posedge): state=HUNT, history=0, fill count=0, bit count=0,
//    data_out=0, valid=0, parity_err=0, busy=0. Reset overrides all other activity at any point.
//  - All outputs are registered. No combinational path from i to any output.
//  - FSM states: HUNT, DATA, PARITY.
//    - HUNT
//      - hist_n = {hist[SYNC_W-2:0], i}.
//      - fill saturates at SYNC_W and counts bits received since entering HUNT.
//      - Match when hist_n==SYNC and (fill+1)>=SYNC_W. On match go to DATA, bit count=0.
//      - Overlapping patterns are detected. Example: stream 1,0,1,0,1,1 matches on the last bit.
//    - DATA
//      - shreg <= {shreg[DATA_W-2:0], i}; bit count increments each edge.
//      - On the edge that samples bit DATA_W-1:
//        - PARITY_EN=1: go to PARITY.
//        - PARITY_EN=0: data_out <= assembled word, parity_err <= 0, valid <= 1, go to HUNT.
//      - Sync pattern is not searched while in DATA.
//    - PARITY
//      - Sample i as the parity bit.
//      - data_out <= shreg; parity_err <= (^shreg) ^ i; valid <= 1; go to HUNT.
//  - On every entry to HUNT: hist=0 and fill=0. Frames never share bits.
//    A new sync may begin on the edge immediately after the last payload or parity bit.
//  - Timing: let edge k sample the final sync bit.
//    - Payload bits are sampled on edges k+1 .. k+DATA_W.
//    - Parity bit, when present, is sampled on edge k+DATA_W+1.
//    - valid is high for exactly the one cycle following the final sampled edge of the frame.
//  - valid=0 in all other cycles.
//  - data_out and parity_err change only when valid is asserted, or on reset.
//  - busy=1 from the cycle after a match until the cycle valid is asserted (inclusive of neither).
//  - Reset mid-frame: the partial frame is discarded, valid does not pulse,
//    and data_out keeps reset value 0.
// TESTING (DATA_W=8, SYNC_W=4, SYNC=4'b1011, PARITY_EN=1)
//  1. reset=1 for 2 cycles, i toggling -> data_out=0, valid=0, parity_err=0, busy=0 throughout.
//  2. Stream 1011 | 10100101 | 0 -> single valid pulse 9 cycles after the sync match,
//     data_out=8'hA5, parity_err=0, busy=0 afterwards.
//  3. Same stream with parity bit=1 -> valid pulse, data_out=8'hA5, parity_err=1.
//  4. Overlap: 101011 | 00111100 | 0 -> match on the 6th bit, data_out=8'h3C, parity_err=0.
//  5. Payload containing 1011 (8'hB0, parity 1) followed directly by a second frame
//     1011 | 00000001 | 1 -> exactly two valid pulses: 8'hB0 with err=0, then 8'h01 with err=0.
//     No false sync is detected inside a payload.
//  6. reset=1 for one edge after 4 payload bits of a frame -> busy=0 next cycle, no valid pulse.
//     A following complete frame carrying 8'h5A (parity 0) is received correctly.

Source files
------------

// File: rtl/serial_frame_deser.sv
// serial_frame_deser
//   Hunts a registered serial bit stream for a sync word. After a match it
//   deserialises DATA_W payload bits, MSB first, followed by an optional
//   even-parity bit. It emits a one-cycle valid pulse for each frame.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   i           serial bit, one bit sampled per rising edge
//   data_out    last completed payload, held until the next frame completes
//   valid       one-cycle pulse when data_out/parity_err update
//   parity_err  received parity mismatched (meaningful with valid, then held)
//   busy        high while receiving payload or parity
module serial_frame_deser #(
    parameter int                 DATA_W    = 8,
    parameter int                 SYNC_W    = 4,
    parameter logic [SYNC_W-1:0]  SYNC      = 4'b1011,
    parameter bit                 PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              busy
);

    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int FILL_W = $clog2(SYNC_W + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [SYNC_W-1:0]  hist, hist_n, hist_shift;
    logic [FILL_W-1:0]  fill, fill_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [DATA_W-1:0]  shreg, shreg_n, data_n;
    logic               valid_n, perr_n, busy_n;

    assign hist_shift = {hist[SYNC_W-2:0], i};

    // Next-state and next-output logic. Every output is registered below, so
    // there is no combinational path from i to any port.
    always_comb begin
        // NOTE: every signal gets a default first so that no path leaves one
        // unassigned, which would infer a latch.
        state_n = state;
        hist_n  = hist;
        fill_n  = fill;
        cnt_n   = cnt;
        shreg_n = shreg;
        data_n  = data_out;
        perr_n  = parity_err;
        valid_n = 1'b0;

        unique case (state)
            HUNT: begin
                // fill counts bits seen since entering HUNT. A match is
                // accepted only once the history holds SYNC_W real bits.
                if (hist_shift == SYNC && (int'(fill) + 1) >= SYNC_W) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    hist_n  = '0;
                    fill_n  = '0;
                end else begin
                    hist_n = hist_shift;
                    if (int'(fill) < SYNC_W)
                        fill_n = fill + FILL_W'(1);
                end
            end
            DATA: begin
                shreg_n = {shreg[DATA_W-2:0], i};
                cnt_n   = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    if (PARITY_EN) begin
                        state_n = PARITY;
                    end else begin
                        data_n  = shreg_n;
                        perr_n  = 1'b0;
                        valid_n = 1'b1;
                        state_n = HUNT;
                        hist_n  = '0;
                        fill_n  = '0;
                    end
                end
            end
            PARITY: begin
                data_n  = shreg;
                perr_n  = (^shreg) ^ i;
                valid_n = 1'b1;
                state_n = HUNT;
                hist_n  = '0;
                fill_n  = '0;
            end
            default: begin
                state_n = HUNT;
                hist_n  = '0;
                fill_n  = '0;
            end
        endcase

        busy_n = (state_n != HUNT);
    end

    // NOTE: sequential state uses non-blocking assignments only. This keeps
    // every register sampling the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: shreg is also cleared on reset. It is narrow, and this
            // keeps the first frame after reset free of X.
            state      <= HUNT;
            hist       <= '0;
            fill       <= '0;
            cnt        <= '0;
            shreg      <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            hist       <= hist_n;
            fill       <= fill_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            data_out   <= data_n;
            valid      <= valid_n;
            parity_err <= perr_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_serial_frame_deser.sv
// tb_serial_frame_deser
//   Directed bench for serial_frame_deser with DATA_W=8, SYNC_W=4,
//   SYNC=1011 and PARITY_EN=1. Inputs change 1 time unit after each rising
//   edge. Outputs are sampled at the same point, once the edge has settled.
module tb_serial_frame_deser;

    logic       clk = 1'b0;
    logic       reset;
    logic       i;
    logic [7:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       busy;

    int checks = 0;
    int fails  = 0;
    int pulses = 0;

    serial_frame_deser #(
        .DATA_W(8), .SYNC_W(4), .SYNC(4'b1011), .PARITY_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .i(i),
        .data_out(data_out), .valid(valid),
        .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bit, let one rising edge sample it, then settle.
    task automatic step(input logic b);
        i = b;
        @(posedge clk);
        #1;
        if (valid === 1'b1) pulses++;
    endtask

    // Send n bits MSB first from bits[n-1:0]. No checks are made here.
    task automatic send(input logic [15:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) step(bits[k]);
    endtask

    // Payload plus parity bit, with busy/valid checks on each bit. This is
    // called right after the final sync bit.
    task automatic frame(input string tag, input logic [7:0] pay, input logic par,
                         input logic [7:0] exp_data, input logic exp_err);
        check({tag, " busy after sync"}, busy, 1'b1);
        for (int k = 7; k >= 0; k--) begin
            step(pay[k]);
            check({tag, " valid during payload"}, valid, 1'b0);
            check({tag, " busy during payload"}, busy, 1'b1);
        end
        step(par);
        check({tag, " valid"}, valid, 1'b1);
        check({tag, " data_out"}, data_out, exp_data);
        check({tag, " parity_err"}, parity_err, exp_err);
        check({tag, " busy at valid"}, busy, 1'b0);
    endtask

    initial begin
        // 1. Reset with i toggling.
        reset = 1'b1;
        i     = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step(k[0] ? 1'b0 : 1'b1);
            check("reset data_out", data_out, 8'h00);
            check("reset valid", valid, 1'b0);
            check("reset parity_err", parity_err, 1'b0);
            check("reset busy", busy, 1'b0);
        end
        reset = 1'b0;
        step(1'b0);

        // 2. Good frame: A5 has four ones, so parity 0 gives no error.
        send(16'b1011, 4);
        frame("t2", 8'hA5, 1'b0, 8'hA5, 1'b0);
        step(1'b0);
        check("t2 valid drops", valid, 1'b0);
        check("t2 data held", data_out, 8'hA5);

        // 3. Same payload, wrong parity.
        send(16'b1011, 4);
        frame("t3", 8'hA5, 1'b1, 8'hA5, 1'b1);
        step(1'b0);
        check("t3 err held", parity_err, 1'b1);

        // 4. Overlapping sync: 101011 should match on the sixth bit only.
        send(16'b10101, 5);
        check("t4 no early match", busy, 1'b0);
        step(1'b1);
        frame("t4", 8'h3C, 1'b0, 8'h3C, 1'b0);

        // 5. Payload B0 contains 1011, and a second frame follows at once.
        send(16'b1011, 4);
        frame("t5a", 8'hB0, 1'b1, 8'hB0, 1'b0);
        step(1'b1);
        check("t5 valid single", valid, 1'b0);
        check("t5 data held", data_out, 8'hB0);
        send(16'b011, 3);
        frame("t5b", 8'h01, 1'b1, 8'h01, 1'b0);

        // 6. Reset after four payload bits discards the partial frame.
        step(1'b0);
        send(16'b1011, 4);
        send(16'b0101, 4);
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        check("t6 busy cleared", busy, 1'b0);
        check("t6 no valid", valid, 1'b0);
        check("t6 data reset", data_out, 8'h00);
        send(16'b1011, 4);
        frame("t6", 8'h5A, 1'b0, 8'h5A, 1'b0);
        step(1'b0);

        // Expect six valid pulses in total, one for each completed frame.
        check("total valid pulses", pulses, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
